// File: rtl/bpu_pkg.sv
// Shared types and counter helpers for the gshare/BTB branch predictor.
// CNT_W-generic helpers operate on a 4-bit container (CNT_W is 2..4).
package bpu_pkg;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JUMP = 2'd1,
        BR_CALL = 2'd2,
        BR_RET  = 2'd3
    } br_type_t;

    function automatic logic [3:0] cnt_max(input int cnt_w);
        return 4'((1 << cnt_w) - 1);
    endfunction

    // Weakly not-taken: just below the MSB threshold.
    function automatic logic [3:0] cnt_weak_nt(input int cnt_w);
        return 4'((1 << (cnt_w - 1)) - 1);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c, input int cnt_w);
        return (c == cnt_max(cnt_w)) ? c : c + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] c);
        return (c == 4'd0) ? c : c - 4'd1;
    endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return address stack; overflow overwrites the oldest entry,
// flush drops the count but leaves the pointer where it is.
module bpu_ras import bpu_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W:0]   cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            cnt <= (cnt == (PTR_W+1)'(DEPTH)) ? cnt : cnt + (PTR_W+1)'(1);
        end else if (pop) begin
            ptr <= ptr - PTR_W'(1);
            cnt <= cnt - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[ptr] <= push_data;
    end

    assign top   = mem[ptr - PTR_W'(1)];
    assign empty = (cnt == '0);

endmodule

// File: rtl/bpu_gshare_btb.sv
// Gshare + tagged direct-mapped BTB branch predictor with registered redirect.
// Optional return address stack enabled by defining RAS_EN.
module bpu_gshare_btb import bpu_pkg::*; #(
    parameter int PC_W        = 32,
    parameter int BTB_ENTRIES = 512,
    parameter int PHT_ENTRIES = 1024,
    parameter int CNT_W       = 2,
    parameter int GHR_W       = 8,
    parameter int RAS_DEPTH   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_en,
    input  logic [PC_W-1:0]  pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             res_valid,
    input  logic [PC_W-1:0]  res_pc,
    input  br_type_t         res_type,
    input  logic             res_taken,
    input  logic [PC_W-1:0]  res_target,
    input  logic             res_pred_taken,
    input  logic [PC_W-1:0]  res_pred_target,
    input  logic [GHR_W-1:0] res_ghr,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc
);

    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W     = PC_W - 2 - BTB_IDX_W;
    localparam int PHT_IDX_W = $clog2(PHT_ENTRIES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_weak_nt(CNT_W));

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
    logic [PC_W-1:0]        btb_tgt [BTB_ENTRIES];
    br_type_t               btb_type [BTB_ENTRIES];
    logic [CNT_W-1:0]       pht [PHT_ENTRIES];
    logic [GHR_W-1:0]       ghr;

    // ---- lookup ----
    logic [BTB_IDX_W-1:0] lk_idx;
    logic [PHT_IDX_W-1:0] lk_pht_idx;
    logic                 lk_hit, lk_dir;
    br_type_t             lk_type;
    logic [PC_W-1:0]      pc_plus4;
    logic                 ras_valid;
    logic [PC_W-1:0]      ras_top;

    assign pc_plus4   = pc + PC_W'(4);
    assign lk_idx     = pc[BTB_IDX_W+1:2];
    assign lk_hit     = btb_valid[lk_idx] && (btb_tag[lk_idx] == pc[PC_W-1:BTB_IDX_W+2]);
    assign lk_type    = btb_type[lk_idx];
    assign lk_pht_idx = pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
    assign lk_dir     = pht[lk_pht_idx][CNT_W-1];
    assign pred_ghr   = ghr;

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_plus4;
        if (lk_hit) begin
            pred_target = btb_tgt[lk_idx];
            case (lk_type)
                BR_COND: pred_taken = lk_dir;
                BR_RET: begin
                    pred_taken = 1'b1;
                    if (ras_valid)
                        pred_target = ras_top;
                end
                default: pred_taken = 1'b1;
            endcase
        end
    end

    // ---- resolve ----
    logic                 mispredict;
    logic [BTB_IDX_W-1:0] res_idx;
    logic [PHT_IDX_W-1:0] res_pht_idx;

    assign mispredict  = (res_taken != res_pred_taken) ||
                         (res_taken && (res_target != res_pred_target));
    assign res_idx     = res_pc[BTB_IDX_W+1:2];
    assign res_pht_idx = res_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(res_ghr);

    // Repair from the resolved branch wins over same-cycle speculation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ghr <= '0;
        else if (res_valid && mispredict)
            ghr <= (res_type == BR_COND) ? {res_ghr[GHR_W-2:0], res_taken} : res_ghr;
        else if (pc_en && lk_hit && lk_type == BR_COND)
            ghr <= {ghr[GHR_W-2:0], lk_dir};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= res_valid && mispredict;
            if (res_valid)
                redirect_pc <= res_taken ? res_target : res_pc + PC_W'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++)
                pht[i] <= CNT_INIT;
        end else if (res_valid && res_type == BR_COND) begin
            pht[res_pht_idx] <= res_taken ? CNT_W'(sat_inc(4'(pht[res_pht_idx]), CNT_W))
                                          : CNT_W'(sat_dec(4'(pht[res_pht_idx])));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            btb_valid <= '0;
        else if (res_valid && res_taken)
            btb_valid[res_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (res_valid && res_taken) begin
            btb_tag[res_idx]  <= res_pc[PC_W-1:BTB_IDX_W+2];
            btb_tgt[res_idx]  <= res_target;
            btb_type[res_idx] <= res_type;
        end
    end

`ifdef RAS_EN
    logic ras_empty;

    bpu_ras #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (pc_en && lk_hit && lk_type == BR_CALL),
        .pop       (pc_en && lk_hit && lk_type == BR_RET && ras_valid),
        .flush     (res_valid && mispredict),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty)
    );
    assign ras_valid = !ras_empty;
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    assign ras_valid = 1'b0;
    assign ras_top   = pc_plus4;
`endif

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pc[1:0], res_pc[1:0]};

endmodule

// File: tb/tb_bpu_gshare_btb.sv
// Scoreboarded bench for bpu_gshare_btb; RAS scenario built only with RAS_EN.
module tb_bpu_gshare_btb;
    import bpu_pkg::*;

    logic        clk, rst, pc_en;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghr;
    logic        res_valid, res_taken, res_pred_taken;
    logic [31:0] res_pc, res_target, res_pred_target;
    br_type_t    res_type;
    logic [7:0]  res_ghr;
    logic        redirect;
    logic [31:0] redirect_pc;

    bpu_gshare_btb #(
        .PC_W(32), .BTB_ENTRIES(512), .PHT_ENTRIES(1024),
        .CNT_W(2), .GHR_W(8), .RAS_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .pc(pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
        .res_valid(res_valid), .res_pc(res_pc), .res_type(res_type),
        .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .res_ghr(res_ghr), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic rd; logic [31:0] rpc; } exp_t;
    exp_t       sb[$];
    exp_t       e;
    int         errors = 0, checks = 0;
    logic [7:0] ghr_m;
    logic [1:0] pht_m [1024];

    task automatic model_reset();
        ghr_m = 8'h00;
        for (int i = 0; i < 1024; i++) pht_m[i] = 2'd1;
        sb.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b1; pc_en = 1'b0; pc = '0; res_valid = 1'b0;
        res_pc = '0; res_type = BR_COND; res_taken = 1'b0; res_target = '0;
        res_pred_taken = 1'b0; res_pred_target = '0; res_ghr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        model_reset();
    endtask

    task automatic lookup(input logic [31:0] a, input logic en);
        @(negedge clk); pc = a; pc_en = en; #1;
    endtask

    task automatic step();
        @(posedge clk); #1; pc_en = 1'b0;
    endtask

    // Drives one resolve at the negedge and pushes the expected redirect.
    task automatic res_start(input logic [31:0] rpc, input br_type_t t, input logic tk,
                             input logic [31:0] tgt, input logic ptk,
                             input logic [31:0] ptgt, input logic [7:0] rghr);
        logic       mis;
        logic [9:0] pi;
        @(negedge clk);
        res_valid = 1'b1; res_pc = rpc; res_type = t; res_taken = tk; res_target = tgt;
        res_pred_taken = ptk; res_pred_target = ptgt; res_ghr = rghr;
        mis = (tk != ptk) || (tk && tgt != ptgt);
        sb.push_back('{mis, tk ? tgt : rpc + 32'd4});
        if (mis) ghr_m = (t == BR_COND) ? {rghr[6:0], tk} : rghr;
        if (t == BR_COND) begin
            pi = rpc[11:2] ^ {2'b00, rghr};
            if (tk) pht_m[pi] = (pht_m[pi] == 2'd3) ? 2'd3 : pht_m[pi] + 2'd1;
            else    pht_m[pi] = (pht_m[pi] == 2'd0) ? 2'd0 : pht_m[pi] - 2'd1;
        end
    endtask

    task automatic res_end();
        @(posedge clk); #1; res_valid = 1'b0; pc_en = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        lookup(32'h100, 1'b0);
        checks++;
        if ({pred_taken, pred_target, pred_ghr} !== {1'b0, 32'h104, 8'h00}) begin
            errors++;
            $display("FAIL reset_lookup: got %0b/%0h/%0h want 0/104/0", pred_taken, pred_target, pred_ghr);
        end
        checks++;
        if ({redirect, redirect_pc} !== 33'd0) begin
            errors++;
            $display("FAIL reset_redirect: got %0b/%0h want 0/0", redirect, redirect_pc);
        end
    endtask

    task automatic test_cond_install();
        res_start(32'h100, BR_COND, 1'b1, 32'h80, 1'b0, 32'h104, ghr_m);
        res_end();
        e = sb.pop_front(); checks++;
        if ({redirect, redirect_pc} !== {1'b1, 32'h80} || {e.rd, e.rpc} !== {1'b1, 32'h80}) begin
            errors++;
            $display("FAIL cond_redirect: got %0b/%0h want 1/80", redirect, redirect_pc);
        end
        // A mispredicted JUMP restores GHR to the carried snapshot (0).
        res_start(32'h300, BR_JUMP, 1'b1, 32'h340, 1'b0, 32'h304, 8'h00);
        res_end();
        e = sb.pop_front(); checks++;
        if ({redirect, redirect_pc} !== {e.rd, e.rpc}) begin
            errors++;
            $display("FAIL jump_redirect: got %0b/%0h want %0b/%0h", redirect, redirect_pc, e.rd, e.rpc);
        end
        lookup(32'h100, 1'b0);
        checks++;
        if ({pred_taken, pred_target, pred_ghr} !== {1'b1, 32'h80, 8'h00}) begin
            errors++;
            $display("FAIL cond_hit: got %0b/%0h/%0h want 1/80/0", pred_taken, pred_target, pred_ghr);
        end
    endtask

    task automatic test_saturate();
        logic tk, ptk;
        int   nmis = 0;
        for (int i = 0; i < 9; i++) begin
            tk = (i < 4);
            ptk = pht_m[10'h040][1];
            lookup(32'h100, 1'b0);
            checks++;
            if ({pred_taken, pred_target} !== {ptk, 32'h80}) begin
                errors++;
                $display("FAIL sat_lookup[%0d]: got %0b/%0h want %0b/80", i, pred_taken, pred_target, ptk);
            end
            res_start(32'h100, BR_COND, tk, 32'h80, ptk, 32'h80, 8'h00);
            res_end();
            e = sb.pop_front(); checks++;
            if ({redirect, redirect_pc} !== {e.rd, e.rpc}) begin
                errors++;
                $display("FAIL sat_redirect[%0d]: got %0b/%0h want %0b/%0h", i, redirect, redirect_pc, e.rd, e.rpc);
            end
            if (redirect === 1'b1) nmis++;
        end
        checks++;
        if (nmis != 2) begin
            errors++;
            $display("FAIL sat_mispredicts: got %0d want 2", nmis);
        end
        lookup(32'h100, 1'b0);
        checks++;
        if ({pred_taken, pred_target} !== {1'b0, 32'h80}) begin
            errors++;
            $display("FAIL sat_floor: got %0b/%0h want 0/80", pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        res_start(32'h100, BR_JUMP, 1'b1, 32'h500, 1'b0, 32'h80, ghr_m);
        pc = 32'h100; #1;
        checks++;
        if ({pred_taken, pred_target} !== {1'b0, 32'h80}) begin
            errors++;
            $display("FAIL rw_old_contents: got %0b/%0h want 0/80", pred_taken, pred_target);
        end
        res_end();
        e = sb.pop_front(); checks++;
        if ({redirect, redirect_pc} !== {e.rd, e.rpc}) begin
            errors++;
            $display("FAIL alias_redirect: got %0b/%0h want %0b/%0h", redirect, redirect_pc, e.rd, e.rpc);
        end
        lookup(32'h100, 1'b0);
        checks++;
        if ({pred_taken, pred_target} !== {1'b1, 32'h500}) begin
            errors++;
            $display("FAIL jump_hit: got %0b/%0h want 1/500", pred_taken, pred_target);
        end
        res_start(32'h900, BR_JUMP, 1'b1, 32'h600, 1'b0, 32'h904, ghr_m);
        res_end();
        e = sb.pop_front();
        lookup(32'h100, 1'b0);
        checks++;
        if ({pred_taken, pred_target} !== {1'b0, 32'h104}) begin
            errors++;
            $display("FAIL alias_evicted: got %0b/%0h want 0/104", pred_taken, pred_target);
        end
        lookup(32'h900, 1'b0);
        checks++;
        if ({pred_taken, pred_target} !== {1'b1, 32'h600}) begin
            errors++;
            $display("FAIL alias_new: got %0b/%0h want 1/600", pred_taken, pred_target);
        end
    endtask

    task automatic test_back_to_back();
        res_start(32'h300, BR_JUMP, 1'b1, 32'h340, 1'b1, 32'h380, ghr_m);
        res_end();
        e = sb.pop_front(); checks++;
        if ({redirect, redirect_pc} !== {e.rd, e.rpc}) begin
            errors++;
            $display("FAIL b2b_first: got %0b/%0h want %0b/%0h", redirect, redirect_pc, e.rd, e.rpc);
        end
        res_start(32'h900, BR_JUMP, 1'b1, 32'h600, 1'b0, 32'h904, ghr_m);
        res_end();
        e = sb.pop_front(); checks++;
        if ({redirect, redirect_pc} !== {1'b1, 32'h600} || {e.rd, e.rpc} !== {1'b1, 32'h600}) begin
            errors++;
            $display("FAIL b2b_second: got %0b/%0h want 1/600", redirect, redirect_pc);
        end
        res_start(32'h300, BR_JUMP, 1'b1, 32'h340, 1'b1, 32'h340, ghr_m);
        res_end();
        e = sb.pop_front(); checks++;
        if ({redirect, redirect_pc} !== {e.rd, e.rpc}) begin
            errors++;
            $display("FAIL b2b_correct: got %0b/%0h want %0b/%0h", redirect, redirect_pc, e.rd, e.rpc);
        end
        step();
        checks++;
        if (redirect !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got %0b want 0", redirect);
        end
    endtask

    task automatic test_ghr_repair();
        logic [9:0] pi;
        logic       dir;
        res_start(32'h140, BR_COND, 1'b1, 32'h40, 1'b0, 32'h144, ghr_m);
        res_end();
        e = sb.pop_front(); checks++;
        if ({redirect, redirect_pc} !== {e.rd, e.rpc}) begin
            errors++;
            $display("FAIL ghr_install: got %0b/%0h want %0b/%0h", redirect, redirect_pc, e.rd, e.rpc);
        end
        for (int k = 0; k < 2; k++) begin
            pi  = 10'h050 ^ {2'b00, ghr_m};
            dir = pht_m[pi][1];
            lookup(32'h140, 1'b1);
            checks++;
            if ({pred_taken, pred_target, pred_ghr} !== {dir, 32'h40, ghr_m}) begin
                errors++;
                $display("FAIL ghr_spec[%0d]: got %0b/%0h/%0h want %0b/40/%0h", k, pred_taken, pred_target, pred_ghr, dir, ghr_m);
            end
            ghr_m = {ghr_m[6:0], dir};
            step();
        end
        res_start(32'h180, BR_COND, 1'b1, 32'h1c0, 1'b0, 32'h184, 8'h05);
        pc = 32'h140; pc_en = 1'b1; #1;
        checks++;
        if (pred_target !== 32'h40) begin
            errors++;
            $display("FAIL ghr_coincide_hit: got %0h want 40", pred_target);
        end
        res_end();
        e = sb.pop_front(); checks++;
        if ({redirect, redirect_pc} !== {e.rd, e.rpc}) begin
            errors++;
            $display("FAIL ghr_redirect: got %0b/%0h want %0b/%0h", redirect, redirect_pc, e.rd, e.rpc);
        end
        checks++;
        if (pred_ghr !== 8'h0B) begin
            errors++;
            $display("FAIL ghr_repair: got %0h want 0b", pred_ghr);
        end
    endtask

`ifdef RAS_EN
    task automatic test_ras();
        logic [31:0] ras_m[$];
        logic [31:0] exp_t_tgt;
        res_start(32'h480, BR_RET, 1'b1, 32'h700, 1'b0, 32'h484, ghr_m);
        res_end();
        e = sb.pop_front();
        for (int i = 0; i < 9; i++) begin
            res_start(32'h400 + 32'(4*i), BR_CALL, 1'b1, 32'h800, 1'b0, 32'h0, ghr_m);
            res_end();
            e = sb.pop_front();
        end
        for (int i = 0; i < 9; i++) begin
            lookup(32'h400 + 32'(4*i), 1'b1);
            checks++;
            if ({pred_taken, pred_target} !== {1'b1, 32'h800}) begin
                errors++;
                $display("FAIL ras_call[%0d]: got %0b/%0h want 1/800", i, pred_taken, pred_target);
            end
            ras_m.push_back(32'h404 + 32'(4*i));
            if (ras_m.size() > 8) void'(ras_m.pop_front());
            step();
        end
        for (int i = 0; i < 9; i++) begin
            exp_t_tgt = (ras_m.size() > 0) ? ras_m[$] : 32'h700;
            lookup(32'h480, 1'b1);
            checks++;
            if ({pred_taken, pred_target} !== {1'b1, exp_t_tgt}) begin
                errors++;
                $display("FAIL ras_ret[%0d]: got %0b/%0h want 1/%0h", i, pred_taken, pred_target, exp_t_tgt);
            end
            if (ras_m.size() > 0) void'(ras_m.pop_back());
            step();
        end
    endtask
`endif

    task automatic test_mid_reset();
        res_start(32'h300, BR_JUMP, 1'b1, 32'h340, 1'b0, 32'h304, 8'h3C);
        res_end();
        e = sb.pop_front(); checks++;
        if ({redirect, redirect_pc, pred_ghr} !== {1'b1, 32'h340, 8'h3C}) begin
            errors++;
            $display("FAIL midrst_pre: got %0b/%0h/%0h want 1/340/3c", redirect, redirect_pc, pred_ghr);
        end
        @(negedge clk); pc = 32'h140; rst = 1'b1; #1;
        checks++;
        if ({redirect, redirect_pc, pred_ghr} !== {1'b0, 32'h0, 8'h00}) begin
            errors++;
            $display("FAIL midrst_async: got %0b/%0h/%0h want 0/0/0", redirect, redirect_pc, pred_ghr);
        end
        checks++;
        if ({pred_taken, pred_target} !== {1'b0, 32'h144}) begin
            errors++;
            $display("FAIL midrst_btb: got %0b/%0h want 0/144", pred_taken, pred_target);
        end
        @(negedge clk); rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cond_install();
        test_saturate();
        test_alias();
        test_back_to_back();
        test_ghr_repair();
`ifdef RAS_EN
        test_ras();
`endif
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
